// File: rtl/axis_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axis_pkg: shared beat type, sizing helper and limits for the elastic buffer.
// Rev 1.0
// ----------------------------------------------------------------------------
package axis_pkg;

  localparam int AXIS_DATA_WIDTH   = 64;
  localparam int AXIS_USER_WIDTH   = 1;
  localparam int AXIS_EB_MIN_DEPTH = 2;

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] data;
    logic                       last;
    logic [AXIS_USER_WIDTH-1:0] user;
  } axis_beat_t;

  // One extra MSB distinguishes full from empty when the index bits match.
  function automatic int axis_ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_eb_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axis_eb_ram: 1W1R register array with a registered read-ahead output.
// Rev 1.0
// ----------------------------------------------------------------------------
module axis_eb_ram
  import axis_pkg::*;
#(
  parameter int WIDTH = 66,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // raddr_i is the head pointer after this edge; bypass the write so an
  // empty buffer presents its first beat one cycle after the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (we_i && (waddr_i == raddr_i)) begin
      rdata_q <= wdata_i;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/axis_elastic_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axis_elastic_buffer: N-deep AXI4-Stream FIFO, registered ready/valid/afull.
// Option: AXIS_EB_PKT_MODE_EN enables store-and-forward packet mode. Rev 1.0
// ----------------------------------------------------------------------------
module axis_elastic_buffer
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int USER_WIDTH   = 1,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    s_tdata,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic                     s_tlast,
  input  logic [USER_WIDTH-1:0]    s_tuser,
  output logic [DATA_WIDTH-1:0]    m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic [USER_WIDTH-1:0]    m_tuser,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     s_afull
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = axis_ptr_width(DEPTH);
  localparam int BW = DATA_WIDTH + 1 + USER_WIDTH;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          s_tready_q, m_tvalid_q, s_afull_q;
  logic          m_tvalid_d, full_d, empty_d, afull_d;
  logic          wr_fire, rd_fire;
  logic [BW-1:0] wbeat, rbeat;

  assign wr_fire = s_tvalid && s_tready_q;
  assign rd_fire = m_tvalid_q && m_tready;

  assign wr_ptr_d = wr_ptr_q + PW'(wr_fire);
  assign rd_ptr_d = rd_ptr_q + PW'(rd_fire);
  assign count_d  = wr_ptr_d - rd_ptr_d;
  assign empty_d  = (wr_ptr_d == rd_ptr_d);
  assign full_d   = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                    (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  assign afull_d  = (count_d >= PW'(AFULL_THRESH));

  assign wbeat = {s_tdata, s_tlast, s_tuser};

  axis_eb_ram #(
    .WIDTH (BW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_fire),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wbeat),
    .raddr_i (rd_ptr_d[AW-1:0]),
    .rdata_o (rbeat)
  );

  assign m_tdata = rbeat[BW-1 -: DATA_WIDTH];
  assign m_tlast = rbeat[USER_WIDTH];
  assign m_tuser = rbeat[USER_WIDTH-1:0];

`ifdef AXIS_EB_PKT_MODE_EN
  logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          ovf_q, ovf_d;

  // ovf lets a frame larger than the buffer stream through instead of deadlocking.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (wr_fire && s_tlast) pkt_cnt_d = pkt_cnt_d + PW'(1);
    if (rd_fire && m_tlast) pkt_cnt_d = pkt_cnt_d - PW'(1);
    ovf_d = ovf_q && !(rd_fire && m_tlast);
    if (full_d && (pkt_cnt_d == '0)) ovf_d = 1'b1;
    m_tvalid_d = !empty_d && ((pkt_cnt_d != '0) || ovf_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      ovf_q     <= ovf_d;
    end
  end
`else
  assign m_tvalid_d = !empty_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      s_tready_q <= 1'b1;
      m_tvalid_q <= 1'b0;
      s_afull_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      s_tready_q <= !full_d;
      m_tvalid_q <= m_tvalid_d;
      s_afull_q  <= afull_d;
    end
  end

  assign s_tready = s_tready_q;
  assign m_tvalid = m_tvalid_q;
  assign count    = count_q;
  assign s_afull  = s_afull_q;

`ifndef SYNTHESIS
  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (m_tvalid && !m_tready) |=>
      (m_tvalid && $stable(m_tdata) && $stable(m_tlast) && $stable(m_tuser)));

  a_count: assert property (@(posedge clk) disable iff (!rst_n)
    count <= PW'(DEPTH));

  a_depth: assert property (@(posedge clk)
    (((DEPTH & (DEPTH - 1)) == 0) && (DEPTH >= AXIS_EB_MIN_DEPTH)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_elastic_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_axis_elastic_buffer: directed and scoreboard checks of axis_elastic_buffer.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_axis_elastic_buffer;
  import axis_pkg::*;

  localparam int DW    = 64;
  localparam int UW    = 1;
  localparam int DEPTH = 8;
  localparam int AF    = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [UW-1:0] s_tuser;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic [UW-1:0] m_tuser;
  logic [3:0]    count;
  logic          s_afull;

  always #5 clk = ~clk;

  axis_elastic_buffer #(
    .DATA_WIDTH   (DW),
    .USER_WIDTH   (UW),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AF)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tlast  (s_tlast),
    .s_tuser  (s_tuser),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .m_tuser  (m_tuser),
    .count    (count),
    .s_afull  (s_afull)
  );

  axis_beat_t q[$];
  int         pkt_m;
  bit         ovf_m;
  bit         last_wr;
  bit         saw_full;
  int         total;
  int         bad;
  int         cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit mv();
`ifdef AXIS_EB_PKT_MODE_EN
    return (q.size() != 0) && ((pkt_m != 0) || ovf_m);
`else
    return q.size() != 0;
`endif
  endfunction

  task automatic check_all();
    chk("s_tready", 64'(s_tready), 64'(q.size() < DEPTH));
    chk("m_tvalid", 64'(m_tvalid), 64'(mv()));
    chk("count",    64'(count),    64'(q.size()));
    chk("s_afull",  64'(s_afull),  64'(q.size() >= AF));
    if (mv()) begin
      chk("m_tdata", m_tdata,          q[0].data);
      chk("m_tlast", 64'(m_tlast),     64'(q[0].last));
      chk("m_tuser", 64'(m_tuser),     64'(q[0].user));
    end
    if (!s_tready) saw_full = 1'b1;
  endtask

  // One clock: reference queue advances on the modelled handshakes, then all outputs are checked.
  task automatic cycle();
    bit         wr, rd;
    axis_beat_t b, tmp;
    wr     = s_tvalid && (q.size() < DEPTH);
    rd     = mv() && m_tready;
    b.data = s_tdata;
    b.last = s_tlast;
    b.user = s_tuser;
    @(posedge clk);
    #1;
    cyc++;
    if (rd) begin
      if (q[0].last) begin
        pkt_m--;
        ovf_m = 1'b0;
      end
      tmp = q.pop_front();
    end
    if (wr) begin
      q.push_back(b);
      if (b.last) pkt_m++;
    end
    if ((q.size() == DEPTH) && (pkt_m == 0)) ovf_m = 1'b1;
    last_wr = wr;
    check_all();
  endtask

  task automatic send_beat(input logic [63:0] d, input bit l, input bit u, input bit force_rd);
    int n;
    n        = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    s_tuser  = u;
    do begin
      if (force_rd && (n > 0)) m_tready = 1'b1;
      cycle();
      n++;
    end while (!last_wr && (n < 64));
    chk("send_accept", 64'(last_wr), 64'd1);
  endtask

  task automatic drain();
    int n;
    n        = 0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    while ((q.size() != 0) && (n < 64)) begin
      cycle();
      n++;
    end
    cycle();
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_valid", 64'(m_tvalid), 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int seq;
    bit pending;

    total = 0; bad = 0; cyc = 0; pkt_m = 0; ovf_m = 1'b0; saw_full = 1'b0; last_wr = 1'b0;
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tuser = '0; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_tready", 64'(s_tready), 64'd1);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_count",    64'(count),    64'd0);
    chk("rst_s_afull",  64'(s_afull),  64'd0);
    rst_n = 1'b1;

    // Streaming at full rate: one beat per cycle, occupancy never above 1.
    m_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      c0 = cyc;
      send_beat(64'(i), 1'b1, (i % 2) == 1, 1'b0);
      chk("t1_rate", 64'(cyc - c0), 64'd1);
      chk("t1_count_le1", 64'(count <= 4'd1), 64'd1);
      if (i == 0) begin
        chk("t1_first_valid", 64'(m_tvalid), 64'd1);
        chk("t1_first_data",  m_tdata,       64'h0);
      end
    end
    drain();

    // Fill to full with the sink stalled.
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_beat(64'h100 + 64'(i), 1'b1, 1'b0, 1'b0);
      chk("t2_count", 64'(count),   64'(i + 1));
      chk("t2_afull", 64'(s_afull), 64'((i + 1) >= 6));
    end
    chk("t2_full_ready", 64'(s_tready), 64'd0);
    s_tvalid = 1'b1;
    s_tdata  = 64'hDEAD;
    cycle();
    chk("t2_ignored_write", 64'(count), 64'd8);
    m_tready = 1'b1;
    cycle();
    chk("t2_ready_back", 64'(s_tready), 64'd1);
    chk("t2_count_after_read", 64'(count), 64'd7);
    s_tvalid = 1'b0;
    drain();

    // Random valid/ready with random tlast/tuser.
    seq = 0; pending = 1'b0; c0 = cyc;
    while ((seq < 10000) && ((cyc - c0) < 60000)) begin
      if (!pending) begin
        s_tdata = {32'hC0DE0000, 32'(seq)};
        s_tlast = ($urandom_range(0, 3) == 0);
        s_tuser = 1'($urandom_range(0, 1));
        pending = 1'b1;
      end
      s_tvalid = 1'($urandom_range(0, 1));
      m_tready = 1'($urandom_range(0, 1));
      cycle();
      if (last_wr) begin
        pending = 1'b0;
        seq++;
      end
    end
    chk("t3_beats", 64'(seq), 64'd10000);
    send_beat(64'hC0DE_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1);
    drain();

    // Pointer wrap: 27 beats with the sink stalled every other beat.
    saw_full = 1'b0;
    for (int k = 0; k < 3 * DEPTH + 3; k++) begin
      m_tready = (k % 2) == 1;
      send_beat(64'h400 + 64'(k), 1'b1, (k % 2) == 1, 1'b1);
    end
    s_tvalid = 1'b0;
    chk("t4_saw_full", 64'(saw_full), 64'd1);
    drain();

`ifdef AXIS_EB_PKT_MODE_EN
    // Store-and-forward: nothing leaves until tlast is stored.
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_beat(64'h500 + 64'(i), i == 3, 1'b0, 1'b0);
      chk("t5_pkt_valid", 64'(m_tvalid), 64'(i == 3));
    end
    s_tvalid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cycle();
      chk("t5_b2b", 64'(m_tvalid), 64'd1);
    end
    cycle();
    chk("t5_pkt_done", 64'(count), 64'd0);
    // Oversize frame: released once the buffer fills without a complete packet.
    for (int i = 0; i < 12; i++) begin
      send_beat(64'h600 + 64'(i), i == 11, 1'b0, 1'b0);
      if (i == 6) chk("t5_ovf_hold", 64'(m_tvalid), 64'd0);
      if (i == 7) chk("t5_ovf_valid", 64'(m_tvalid), 64'd1);
    end
    drain();
`endif

    // Asynchronous reset with five beats stored.
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_beat(64'h700 + 64'(i), 1'b1, 1'b0, 1'b0);
    end
    s_tvalid = 1'b0;
    cycle();
    chk("t6_stored", 64'(count), 64'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(m_tvalid), 64'd0);
    chk("t6_rst_count", 64'(count),    64'd0);
    chk("t6_rst_ready", 64'(s_tready), 64'd1);
    chk("t6_rst_afull", 64'(s_afull),  64'd0);
    q.delete();
    pkt_m = 0;
    ovf_m = 1'b0;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    m_tready = 1'b1;
    send_beat(64'hAA, 1'b1, 1'b0, 1'b0);
    chk("t6_first_valid", 64'(m_tvalid), 64'd1);
    chk("t6_first_data",  m_tdata,       64'hAA);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
